// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store sequencer.
//   funct3_e : RV64I load funct3 encodings, with store aliases SB/SH/SW/SD
//   state_e  : controller FSM states
//   size_e   : access size (log2 of byte count)
//   helpers  : access_size, load_signed, size_mask, align_mask
package lsu_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LD  = 3'b011,
    LBU = 3'b100,
    LHU = 3'b101,
    LWU = 3'b110
  } funct3_e;

  localparam funct3_e SB = LB;
  localparam funct3_e SH = LH;
  localparam funct3_e SW = LW;
  localparam funct3_e SD = LD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_LOAD_RESP,
    ST_WRITE,
    ST_FAULT
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  localparam logic [63:0] MASK_B = 64'h0000_0000_0000_00FF;
  localparam logic [63:0] MASK_H = 64'h0000_0000_0000_FFFF;
  localparam logic [63:0] MASK_W = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] MASK_D = 64'hFFFF_FFFF_FFFF_FFFF;

  // Unlisted encodings (3'b111 load, 1xx store) fall through to doubleword.
  function automatic size_e access_size(input logic we, input logic [2:0] f3);
    size_e sz;
    if (we) begin
      case (f3)
        SB:      sz = SZ_B;
        SH:      sz = SZ_H;
        SW:      sz = SZ_W;
        default: sz = SZ_D;
      endcase
    end else begin
      case (f3)
        LB, LBU: sz = SZ_B;
        LH, LHU: sz = SZ_H;
        LW, LWU: sz = SZ_W;
        default: sz = SZ_D;
      endcase
    end
    return sz;
  endfunction

  function automatic logic load_signed(input logic [2:0] f3);
    return (f3 == LB) || (f3 == LH) || (f3 == LW);
  endfunction

  function automatic logic [63:0] size_mask(input size_e sz);
    logic [63:0] m;
    case (sz)
      SZ_B:    m = MASK_B;
      SZ_H:    m = MASK_H;
      SZ_W:    m = MASK_W;
      default: m = MASK_D;
    endcase
    return m;
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input size_e sz);
    logic [2:0] m;
    case (sz)
      SZ_B:    m = 3'b000;
      SZ_H:    m = 3'b001;
      SZ_W:    m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane logic for the load/store sequencer.
//   size       : access size
//   sext       : sign-extend the extracted load value
//   off        : byte offset inside the doubleword (already size-aligned)
//   rdata      : doubleword read from memory
//   wdata      : right-aligned store data
//   load_data  : extracted and extended load result
//   merge_data : doubleword with the store bytes merged into rdata
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  size_e            size,
  input  logic             sext,
  input  logic [2:0]       off,
  input  logic [XLEN-1:0]  rdata,
  input  logic [XLEN-1:0]  wdata,
  output logic [XLEN-1:0]  load_data,
  output logic [XLEN-1:0]  merge_data
);

  logic [5:0]      shamt;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] mask;

  assign shamt = {off, 3'b000};

  always_comb begin
    lane = rdata >> shamt;
    mask = size_mask(size) << shamt;
    case (size)
      SZ_B:    load_data = {{(XLEN-8){sext & lane[7]}}, lane[7:0]};
      SZ_H:    load_data = {{(XLEN-16){sext & lane[15]}}, lane[15:0]};
      SZ_W:    load_data = {{(XLEN-32){sext & lane[31]}}, lane[31:0]};
      default: load_data = lane;
    endcase
    // For SD the mask is all ones, so rdata drops out and wdata passes through.
    merge_data = (rdata & ~mask) | ((wdata << shamt) & mask);
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between execute and a 64-bit doubleword
// memory with one-cycle registered read. Sub-doubleword stores are done as
// read-modify-write.
//   Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned -> fault
//   response, no memory access). Undefined: low address bits are cleared
//   to the access size and the access proceeds.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   req_*              : request handshake (valid/ready), we, funct3, addr, wdata
//   resp_valid/data/fault : one-cycle completion pulse and result
//   mem_address/write_data/read/write : memory command, mem_read_data return
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [XLEN-1:0]  req_addr,
  input  logic [XLEN-1:0]  req_wdata,
  output logic             resp_valid,
  output logic [XLEN-1:0]  resp_data,
  output logic             resp_fault,
  output logic [XLEN-1:0]  mem_address,
  output logic [XLEN-1:0]  mem_write_data,
  output logic             mem_read,
  output logic             mem_write,
  input  logic [XLEN-1:0]  mem_read_data
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [2:0]      f3_q;
  logic            we_q;

  logic            accept;
  size_e           req_size;
  size_e           cur_size;
  logic            req_misaligned;
  logic [2:0]      off;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] merge_data;
  logic [XLEN-1:0] dw_addr;

  assign accept   = req_valid && req_ready;
  assign req_size = access_size(req_we, req_funct3);
  assign cur_size = access_size(we_q, f3_q);
  assign dw_addr  = {addr_q[XLEN-1:3], 3'b000};

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_misaligned = |(req_addr[2:0] & align_mask(req_size));
  // Misaligned requests never reach the datapath, so the raw offset is aligned.
  assign off = addr_q[2:0];
`else
  assign req_misaligned = 1'b0;
  assign off = addr_q[2:0] & ~align_mask(cur_size);
`endif

  lsu_align #(.XLEN(XLEN)) u_align (
    .size       (cur_size),
    .sext       (load_signed(f3_q) && !we_q),
    .off        (off),
    .rdata      (mem_read_data),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        f3_q    <= req_funct3;
        we_q    <= req_we;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_data      = '0;
    resp_fault     = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_misaligned)                 state_d = ST_FAULT;
          else if (req_we && req_size == SZ_D) state_d = ST_WRITE;
          else                                state_d = ST_READ;
        end
      end
      ST_READ: begin
        mem_read    = 1'b1;
        mem_address = dw_addr;
        state_d     = we_q ? ST_WRITE : ST_LOAD_RESP;
      end
      ST_LOAD_RESP: begin
        resp_valid = 1'b1;
        resp_data  = load_data;
        state_d    = ST_IDLE;
      end
      ST_WRITE: begin
        mem_write      = 1'b1;
        mem_address    = dw_addr;
        mem_write_data = merge_data;
        resp_valid     = 1'b1;
        state_d        = ST_IDLE;
      end
      ST_FAULT: begin
        resp_valid = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
        resp_fault = 1'b1;
`endif
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are quiet during reset; this also drops a pending RMW write.
    if (rst) begin
      req_ready      = 1'b0;
      resp_valid     = 1'b0;
      resp_data      = '0;
      resp_fault     = 1'b0;
      mem_address    = '0;
      mem_write_data = '0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: self-checking bench for lsu_ctrl. A byte-array reference
// model predicts load results, store effects and response latency; a
// doubleword memory with registered read serves the DUT.
module tb_lsu_ctrl;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        resp_fault;
  logic [63:0] mem_address;
  logic [63:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_read_data;

  always #5 clk = ~clk;

  lsu_ctrl #(.XLEN(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .resp_fault     (resp_fault),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_read_data  (mem_read_data)
  );

  // Doubleword memory, 16 words, one-cycle registered read.
  logic [63:0] mem [16];
  always @(posedge clk) begin
    if (mem_write) mem[mem_address[6:3]] <= mem_write_data;
    if (mem_read)  mem_read_data <= mem[mem_address[6:3]];
  end

  // Reference model: flat byte memory.
  logic [7:0] refmem [128];

  int checks = 0;
  int fails  = 0;

  task automatic check(input string tag, input string what,
                       input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s.%s: got %h expected %h", tag, what, act, exp);
    end
  endtask

  function automatic void ref_access(input logic we, input logic [2:0] f3,
                                     input logic [63:0] addr, input logic [63:0] wdata,
                                     output logic [63:0] data, output logic fault,
                                     output int lat, output logic [63:0] wword);
    int n, ea, base;
    logic [63:0] v;
    logic [63:0] ones;
    ones  = '1;
    n     = we ? (f3[2] ? 8 : (1 << f3[1:0])) : ((f3 == 3'b111) ? 8 : (1 << f3[1:0]));
    data  = '0;
    fault = 1'b0;
    wword = '0;
    ea    = int'(addr[6:0]);
    lat   = 2;
    if (ea % n != 0) begin
      if (TRAP) begin
        fault = 1'b1;
        lat   = 1;
        return;
      end
      ea = ea - (ea % n);
    end
    base = ea - (ea % 8);
    if (we) begin
      for (int i = 0; i < n; i++) refmem[ea+i] = wdata[8*i +: 8];
      for (int i = 0; i < 8; i++) wword[8*i +: 8] = refmem[base+i];
      lat = (n == 8) ? 1 : 2;
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = refmem[ea+i];
      if (n < 8 && !f3[2] && v[8*n-1]) v = v | (ones << (8*n));
      data = v;
    end
  endfunction

  // Issue one request from a negedge; observe until the response, then one
  // more cycle for req_ready. Returns at a negedge.
  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       output logic [63:0] data, output logic fault, output int lat,
                       output int nrd, output int nwr, output logic [63:0] wword,
                       output logic addr_bad, output logic rdy_after);
    int wait_cyc;
    data = '0; fault = 1'b0; lat = -1; nrd = 0; nwr = 0; wword = '0; addr_bad = 1'b0;
    wait_cyc = 0;
    while (!req_ready && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_read || mem_write)
        if (mem_address !== {addr[63:3], 3'b000}) addr_bad = 1'b1;
      if (mem_read) nrd++;
      if (mem_write) begin
        nwr++;
        wword = mem_write_data;
      end
      if (resp_valid) begin
        lat   = k;
        data  = resp_data;
        fault = resp_fault;
        break;
      end
    end
    @(negedge clk);
    rdy_after = req_ready;
  endtask

  task automatic run_check(input string tag, input logic we, input logic [2:0] f3,
                           input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [63:0] exp_data, input logic exp_fault,
                           input int exp_lat, input logic [63:0] exp_wword);
    logic [63:0] data, wword;
    logic fault, addr_bad, rdy;
    int lat, nrd, nwr;
    issue(we, f3, addr, wdata, data, fault, lat, nrd, nwr, wword, addr_bad, rdy);
    check(tag, "latency", 64'(lat), 64'(exp_lat));
    check(tag, "resp_data", data, exp_data);
    check(tag, "resp_fault", {63'b0, fault}, {63'b0, exp_fault});
    check(tag, "mem_read_count", 64'(nrd), (exp_lat == 2) ? 64'd1 : 64'd0);
    check(tag, "mem_write_count", 64'(nwr), (we && !exp_fault) ? 64'd1 : 64'd0);
    if (we && !exp_fault) check(tag, "mem_write_data", wword, exp_wword);
    check(tag, "mem_address_ok", {63'b0, addr_bad}, 64'd0);
    check(tag, "ready_after", {63'b0, rdy}, 64'd1);
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_data;
    logic        exp_fault;
    int          exp_lat;
    logic [63:0] exp_wword;
  } vec_t;

  function automatic vec_t mk(input string name, input logic we, input logic [2:0] f3,
                              input logic [63:0] addr, input logic [63:0] wdata,
                              input logic [63:0] exp_data, input logic exp_fault,
                              input int exp_lat, input logic [63:0] exp_wword);
    vec_t v;
    v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_data = exp_data; v.exp_fault = exp_fault; v.exp_lat = exp_lat;
    v.exp_wword = exp_wword;
    return v;
  endfunction

  task automatic check_quiet(input string tag);
    check(tag, "ctrl_outputs", {59'b0, req_ready, resp_valid, resp_fault, mem_read, mem_write}, 64'd0);
    check(tag, "data_outputs", resp_data | mem_address | mem_write_data, 64'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    vec_t vecs[$];
    logic [63:0] w, m_data, m_wword;
    logic m_fault;
    int m_lat, nw;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; mem_read_data = '0;
    for (int i = 0; i < 16; i++) begin
      w = (i == 2) ? 64'h8877_6655_4433_2211 : {$urandom, $urandom};
      mem[i] = w;
      for (int b = 0; b < 8; b++) refmem[8*i+b] = w[8*b +: 8];
    end

    // Reset state
    repeat (2) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;
    @(negedge clk);
    check("post_reset", "req_ready", {63'b0, req_ready}, 64'd1);
    check("post_reset", "resp_valid", {63'b0, resp_valid}, 64'd0);

    // Directed vectors
    vecs.push_back(mk("ld_10",   0, 3'b011, 64'h10, 0, 64'h8877_6655_4433_2211, 0, 2, 0));
    vecs.push_back(mk("lb_17",   0, 3'b000, 64'h17, 0, 64'hFFFF_FFFF_FFFF_FF88, 0, 2, 0));
    vecs.push_back(mk("lbu_17",  0, 3'b100, 64'h17, 0, 64'h88, 0, 2, 0));
    vecs.push_back(mk("lhu_12",  0, 3'b101, 64'h12, 0, 64'h4433, 0, 2, 0));
    vecs.push_back(mk("lw_14",   0, 3'b010, 64'h14, 0, 64'hFFFF_FFFF_8877_6655, 0, 2, 0));
    vecs.push_back(mk("lwu_14",  0, 3'b110, 64'h14, 0, 64'h8877_6655, 0, 2, 0));
    vecs.push_back(mk("sb_11",   1, 3'b000, 64'h11, 64'hAB, 0, 0, 2, 64'h8877_6655_4433_AB11));
    vecs.push_back(mk("ld_10b",  0, 3'b011, 64'h10, 0, 64'h8877_6655_4433_AB11, 0, 2, 0));
    vecs.push_back(mk("sd_20",   1, 3'b011, 64'h20, 64'h0123_4567_89AB_CDEF, 0, 0, 1, 64'h0123_4567_89AB_CDEF));
    vecs.push_back(mk("ld_20",   0, 3'b011, 64'h20, 0, 64'h0123_4567_89AB_CDEF, 0, 2, 0));
    vecs.push_back(mk("ld111_20",0, 3'b111, 64'h20, 0, 64'h0123_4567_89AB_CDEF, 0, 2, 0));
    vecs.push_back(mk("st100_28",1, 3'b100, 64'h28, 64'hCAFE_F00D_DEAD_BEEF, 0, 0, 1, 64'hCAFE_F00D_DEAD_BEEF));
    vecs.push_back(mk("ld_28",   0, 3'b011, 64'h28, 0, 64'hCAFE_F00D_DEAD_BEEF, 0, 2, 0));
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk("lh_11",   0, 3'b001, 64'h11, 0, 64'h0, 1, 1, 0));
`else
    vecs.push_back(mk("lh_11",   0, 3'b001, 64'h11, 0, 64'hFFFF_FFFF_FFFF_AB11, 0, 2, 0));
`endif

    foreach (vecs[i]) begin
      // keep the model in step with memory
      ref_access(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                 m_data, m_fault, m_lat, m_wword);
      run_check(vecs[i].name, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                vecs[i].exp_data, vecs[i].exp_fault, vecs[i].exp_lat, vecs[i].exp_wword);
    end

    // SH accepted, then reset in the following cycle: the write is dropped.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
    req_addr = 64'h30; req_wdata = 64'hBEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_quiet("rst_mid_n1");
    @(negedge clk);
    check_quiet("rst_mid_n2");
    rst = 1'b0;
    nw = 0;
    repeat (4) begin
      @(negedge clk);
      if (mem_write) nw++;
    end
    check("rst_mid", "late_mem_write", 64'(nw), 64'd0);
    for (int b = 0; b < 8; b++) w[8*b +: 8] = refmem[48+b];
    check("rst_mid", "mem_word_unchanged", mem[6], w);
    run_check("rst_mid_ld", 0, 3'b011, 64'h30, 0, w, 0, 2, 0);

    // Random traffic against the byte-level model
    for (int i = 0; i < 300; i++) begin
      logic        r_we;
      logic [2:0]  r_f3;
      logic [63:0] r_addr, r_wdata;
      r_we    = 1'($urandom_range(0, 1));
      r_f3    = 3'($urandom_range(0, 7));
      r_addr  = 64'($urandom_range(0, 127));
      r_wdata = {$urandom, $urandom};
      ref_access(r_we, r_f3, r_addr, r_wdata, m_data, m_fault, m_lat, m_wword);
      run_check($sformatf("rand%0d", i), r_we, r_f3, r_addr, r_wdata,
                m_data, m_fault, m_lat, m_wword);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
